// File: rtl/uart_rx.sv
// uart_rx: 8n1 UART receiver on an oversampling clock (CLKS_PER_BIT clocks per bit).
// Optional build macro UART_RX_MAJORITY_EN: every sample point takes a 2-of-3 vote
// over three consecutive clocks around the nominal point (requires CLKS_PER_BIT >= 8).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line idle, waiting for rx_s low
//   START | timing to mid start bit, reject glitches
//   DATA  | sampling eight data bits, LSB first
//   STOP  | sampling stop bit; strobe valid or frame_err
//   BREAK | stop bit was low; wait for line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int N = CLKS_PER_BIT;
    localparam int H = N / 2;
`ifdef UART_RX_MAJORITY_EN
    // Decision lands one clock after the nominal point, so the counter must
    // reach N; reloading with 1 keeps the bit period at exactly N clocks.
    localparam int CW        = $clog2(N + 1);
    localparam int DEC_START = H;
    localparam int DEC_BIT   = N;
    localparam int RELOAD    = 1;
`else
    localparam int CW        = $clog2(N);
    localparam int DEC_START = H - 1;
    localparam int DEC_BIT   = N - 1;
    localparam int RELOAD    = 0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dec_cnt;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          at_dec;
    logic          bit_val;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]    vote_q, vote_d;
`endif

    // Next-state, sample decision and strobe generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        dec_cnt   = (state_q == START) ? CW'(DEC_START) : CW'(DEC_BIT);
        at_dec    = (cnt_q == dec_cnt);
`ifdef UART_RX_MAJORITY_EN
        vote_d = vote_q;
        if (cnt_q == dec_cnt - CW'(2)) vote_d[0] = rx_s_q;
        if (cnt_q == dec_cnt - CW'(1)) vote_d[1] = rx_s_q;
        bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
        bit_val = rx_s_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (at_dec) begin
                    if (!bit_val) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                        cnt_d     = CW'(RELOAD);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (at_dec) begin
                    shift_d[bit_idx_q] = bit_val;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    cnt_d              = CW'(RELOAD);
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (at_dec) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // All state: synchroniser, FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            vote_q    <= 2'b11;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            vote_q    <= vote_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
